ram4k_bist: RTL and testbench

//   Built-in self-test initiator for the 4K x 8 RAM (four 1K x 8 blocks behind a 12-bit address).
//   On start: writes the pattern addr[7:0]^SEED to every location, reads every location back,

---
 rtl/ram4k_bist.sv | 139 +++++++++++++
 tb/tb_ram4k_bist.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ram4k_bist.sv
// Built-in self-test initiator for a 4K x 8 synchronous RAM: writes addr^SEED everywhere,
// reads it all back through a one-stage compare pipeline and reports pass, error count and first failure.
module ram4k_bist #(
    parameter int              AW   = 12,
    parameter int              DW   = 8,
    parameter logic [DW-1:0]   SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_din,
    input  logic [DW-1:0]     mem_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [AW:0]       err_count,
    output logic [AW-1:0]     first_err_addr,
    output logic [DW-1:0]     first_err_data
);

    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   ERR_MAX   = {(AW+1){1'b1}};
    localparam logic [AW:0]   ERR_ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return a[DW-1:0] ^ SEED;
    endfunction

    state_t          state_r;
    logic            cmp_valid_r;
    logic [AW-1:0]   cmp_addr_r;
    logic [DW-1:0]   cmp_exp_r;
    logic            mismatch_s;

    // The compare stage holds the address read one cycle earlier; mem_dout now carries its data.
    assign mismatch_s = cmp_valid_r && (mem_dout != cmp_exp_r);

    // Test sequencer, compare pipeline and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= S_IDLE;
            mem_we         <= 1'b0;
            mem_addr       <= {AW{1'b0}};
            mem_din        <= {DW{1'b0}};
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= {(AW+1){1'b0}};
            first_err_addr <= {AW{1'b0}};
            first_err_data <= {DW{1'b0}};
            cmp_valid_r    <= 1'b0;
            cmp_addr_r     <= {AW{1'b0}};
            cmp_exp_r      <= {DW{1'b0}};
        end else begin
            if (mismatch_s) begin
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + ERR_ONE;
                end else begin
                    err_count <= err_count;
                end
                if (err_count == {(AW+1){1'b0}}) begin
                    first_err_addr <= cmp_addr_r;
                    first_err_data <= mem_dout;
                end else begin
                    first_err_addr <= first_err_addr;
                end
            end else begin
                err_count <= err_count;
            end

            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_r        <= S_WRITE;
                        mem_we         <= 1'b1;
                        mem_addr       <= {AW{1'b0}};
                        mem_din        <= pattern({AW{1'b0}});
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= {(AW+1){1'b0}};
                        first_err_addr <= {AW{1'b0}};
                        first_err_data <= {DW{1'b0}};
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_WRITE: begin
                    if (mem_addr == ADDR_LAST) begin
                        state_r  <= S_READ;
                        mem_we   <= 1'b0;
                        mem_addr <= {AW{1'b0}};
                        mem_din  <= {DW{1'b0}};
                    end else begin
                        mem_addr <= mem_addr + ADDR_ONE;
                        mem_din  <= pattern(mem_addr + ADDR_ONE);
                    end
                end
                S_READ: begin
                    cmp_valid_r <= 1'b1;
                    cmp_addr_r  <= mem_addr;
                    cmp_exp_r   <= pattern(mem_addr);
                    if (mem_addr == ADDR_LAST) begin
                        state_r  <= S_DRAIN;
                        mem_addr <= {AW{1'b0}};
                    end else begin
                        mem_addr <= mem_addr + ADDR_ONE;
                    end
                end
                S_DRAIN: begin
                    // The final compare lands this cycle, so fold it into pass directly.
                    cmp_valid_r <= 1'b0;
                    state_r     <= S_DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    pass        <= (err_count == {(AW+1){1'b0}}) && !mismatch_s;
                end
                default: begin
                    state_r     <= S_IDLE;
                    mem_we      <= 1'b0;
                    busy        <= 1'b0;
                    cmp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram4k_bist.sv
// Bench for ram4k_bist: RAM model with injectable faults, result scoreboard fed by a
// spec-level reference model, and a bus monitor checking the write/read sweep.
module tb_ram4k_bist;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int DEPTH = 4096;
    localparam int SEED = 'hA5;

    logic clk = 1'b0;
    logic rst_n, start, mem_we, busy, done, pass;
    logic [AW-1:0] mem_addr, first_err_addr;
    logic [DW-1:0] mem_din, mem_dout, first_err_data;
    logic [AW:0] err_count;

    ram4k_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .first_err_data(first_err_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Fault configuration of the RAM model
    bit stuck_en, corr_en;
    int stuck_bit;
    logic [AW-1:0] corr_addr;
    logic [DW-1:0] corr_val;
    logic [DW-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= stuck_en ? (mem_din & ~(8'h01 << stuck_bit)) : mem_din;
        mem_dout <= (corr_en && mem_addr == corr_addr) ? corr_val : mem[mem_addr];
    end

    typedef struct { bit pass; int err; int faddr; int fdata; } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what a whole test run must report, from the fault description alone.
    function automatic exp_t model();
        exp_t e;
        e.err = 0; e.faddr = 0; e.fdata = 0;
        for (int a = 0; a < DEPTH; a++) begin
            int good, got;
            good = (a % 256) ^ SEED;
            got = good;
            if (stuck_en) got = got & ~(1 << stuck_bit);
            if (corr_en && a == int'(corr_addr)) got = int'(corr_val);
            if (got != good) begin
                if (e.err == 0) begin e.faddr = a; e.fdata = got; end
                e.err++;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    // Monitor
    int busy_cnt, wr_idx, rd_idx, seq_bad;
    bit done_prev, busy_prev;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0; wr_idx = 0; rd_idx = 0; seq_bad = 0;
            done_prev = 0; busy_prev = 0;
        end else begin
            if (busy && !busy_prev)
                check("cleared_on_start", {err_count, first_err_addr, first_err_data, done, pass}, 0);
            if (!busy && mem_we) seq_bad++;
            if (busy) begin
                busy_cnt++;
                if (mem_we) begin
                    if (int'(mem_addr) != wr_idx || int'(mem_din) != ((wr_idx % 256) ^ SEED)) seq_bad++;
                    wr_idx++;
                end else if (wr_idx == DEPTH && rd_idx < DEPTH) begin
                    if (int'(mem_addr) != rd_idx || mem_din != 8'h00) seq_bad++;
                    rd_idx++;
                end
            end
            if (done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no result pending");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("pass", pass, e.pass);
                    check("err_count", err_count, e.err);
                    check("first_err_addr", first_err_addr, e.faddr);
                    check("first_err_data", first_err_data, e.fdata);
                    check("busy_cycles", busy_cnt, 2 * DEPTH + 1);
                    check("write_count", wr_idx, DEPTH);
                    check("read_count", rd_idx, DEPTH);
                    check("bus_sequence_errors", seq_bad, 0);
                end
                busy_cnt = 0; wr_idx = 0; rd_idx = 0; seq_bad = 0;
            end
            done_prev = done;
            busy_prev = busy;
        end
    end

    task automatic set_fault(input bit se, input int sb, input bit ce, input int ca, input int cv);
        stuck_en = se; stuck_bit = sb; corr_en = ce;
        corr_addr = ca[AW-1:0]; corr_val = cv[DW-1:0];
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic issue();
        sb_q.push_back(model());
        pulse_start();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 9000) begin @(negedge clk); n++; end
        check(name, done, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        set_fault(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_flags", {busy, done, pass}, 0);
        check("rst_results", {err_count, first_err_addr, first_err_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good RAM
        issue(); wait_done("t1_done");
        check("t1_pass", pass, 1'b1);

        // Data bit 3 stuck at 0
        set_fault(1, 3, 0, 0, 0);
        issue(); wait_done("t2_done");
        check("t2_err", err_count, 2048);
        check("t2_faddr", first_err_addr, 12'h008);
        check("t2_fdata", first_err_data, 8'hA5);

        // Rerun from DONE after a failure, good RAM
        set_fault(0, 0, 0, 0, 0);
        issue(); wait_done("t6_done");
        check("t6_pass", pass, 1'b1);

        // Single corrupted read
        set_fault(0, 0, 1, 'hC07, 'h00);
        issue(); wait_done("t3_done");
        check("t3_result", {pass, err_count, first_err_addr, first_err_data}, {1'b0, 13'd1, 12'hC07, 8'h00});

        // start while busy is ignored
        set_fault(0, 0, 0, 0, 0);
        issue();
        repeat (98) @(negedge clk);
        pulse_start();
        wait_done("t4_done");

        // Reset mid-run
        pulse_start();
        repeat (5000) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_abort", {mem_we, busy, done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(); wait_done("t5_done");
        check("t5_pass", pass, 1'b1);

        // Randomized fault mixes
        for (int i = 0; i < 3; i++) begin
            set_fault(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                      int'($urandom_range(0, 255)));
            issue(); wait_done("rand_done");
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
